menu_cursor: RTL and testbench

MENU_CURSOR -- requirements
Module: menu_cursor

---
 rtl/menu_pkg.sv | 24 ++
 rtl/vga_pkg.sv | 16 +
 rtl/vga_if.sv | 13 +
 rtl/key_edge.sv | 32 +++
 rtl/menu_cursor.sv | 145 ++++++++++++++
 tb/tb_menu_cursor.sv | 318 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/menu_pkg.sv
// Navigation FSM states, key bit positions and the wrapping selection step.
package menu_pkg;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_CONFIRM      = 2'd1,
    S_WAIT_RELEASE = 2'd2
  } nav_state_t;

  // Bit positions of the keys inside the shared edge detector vector.
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_ENTER = 2;
  localparam int N_KEYS    = 3;

  // Move the selection one step, wrapping between 0 and last.
  function automatic logic [1:0] sel_step(input logic [1:0] sel,
                                          input logic       inc,
                                          input logic [1:0] last);
    if (inc) return (sel == last) ? 2'd0 : sel + 2'd1;
    else     return (sel == 2'd0) ? last : sel - 2'd1;
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// Screen timing constants and the default geometry of the menu cursor box.
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  // Default menu item box geometry. The item column is centred horizontally.
  localparam int             MENU_ITEM_X     = 412;
  localparam int             MENU_ITEM_Y0    = 300;
  localparam int             MENU_ITEM_W     = 200;
  localparam int             MENU_ITEM_H     = 48;
  localparam int             MENU_ITEM_PITCH = 80;
  localparam int             MENU_BORDER     = 3;
  localparam logic [11:0]    MENU_CUR_RGB    = 12'hF_F_0;

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle: timing counters, sync, blanking and colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/key_edge.sv
// Rising-edge detector for a vector of key levels. The first sample after
// reset primes the history with the live level, so a key held through reset
// never looks like a fresh press.
module key_edge #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_level,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_prev;
  logic             r_armed;

  // Register the level and its previous sample; prime history on first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
      r_prev  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_level <= i_level;
      r_prev  <= r_armed ? r_level : i_level;
      r_armed <= 1'b1;
    end
  end

  assign o_rise = r_level & ~r_prev;

endmodule

// File: rtl/menu_cursor.sv
// Menu cursor: keyboard navigation FSM plus a rectangular frame overlaid on
// the selected item of a rendered VGA stream.
//
// Handshake: sel_valid is a one-cycle strobe with no back-pressure; menu_sel
// is stable and meaningful in every cycle where sel_valid is high.
module menu_cursor
  import vga_pkg::*;
  import menu_pkg::*;
#(
  parameter int          ITEMS      = 3,
  parameter int          ITEM_X     = MENU_ITEM_X,
  parameter int          ITEM_Y0    = MENU_ITEM_Y0,
  parameter int          ITEM_W     = MENU_ITEM_W,
  parameter int          ITEM_H     = MENU_ITEM_H,
  parameter int          ITEM_PITCH = MENU_ITEM_PITCH,
  parameter int          BORDER     = MENU_BORDER,
  parameter logic [11:0] CUR_RGB    = MENU_CUR_RGB
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  vga_if.in          in,
  vga_if.out         out,
  output logic [1:0] menu_sel,
  output logic       sel_valid,
  output nav_state_t o_dbg_state
);

  localparam logic [1:0]  LAST_SEL = 2'(ITEMS - 1);
  localparam logic [10:0] X_LO     = 11'(ITEM_X);
  localparam logic [10:0] X_HI     = 11'(ITEM_X + ITEM_W - 1);
  localparam logic [10:0] XI_LO    = 11'(ITEM_X + BORDER);
  localparam logic [10:0] XI_HI    = 11'(ITEM_X + ITEM_W - 1 - BORDER);

  nav_state_t        r_state;
  nav_state_t        w_state_nxt;
  logic [1:0]        r_menu_sel;
  logic [1:0]        w_sel_nxt;
  logic [1:0]        r_disp_sel;
  logic              r_vblnk_d;
  logic [N_KEYS-1:0] w_rise;

  logic [10:0] w_y0;
  logic [10:0] w_y_hi;
  logic [10:0] w_yi_lo;
  logic [10:0] w_yi_hi;
  logic        w_in_box;
  logic        w_in_interior;
  logic        w_cursor_on;

  key_edge #(.WIDTH(N_KEYS)) u_key_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level ({key_enter, key_down, key_up}),
    .o_rise  (w_rise)
  );

  // State and selection registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_menu_sel <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_menu_sel <= w_sel_nxt;
    end
  end

  // Next state and selection; enter wins over a same-cycle up/down edge.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_menu_sel;
    case (r_state)
      S_IDLE: begin
        if (w_rise[KEY_ENTER]) begin
          w_state_nxt = S_CONFIRM;
        end else if (w_rise[KEY_UP] ^ w_rise[KEY_DOWN]) begin
          w_sel_nxt = sel_step(r_menu_sel, w_rise[KEY_DOWN], LAST_SEL);
        end
      end
      S_CONFIRM: begin
        w_state_nxt = S_WAIT_RELEASE;
      end
      S_WAIT_RELEASE: begin
        if (!(key_up || key_down || key_enter)) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Decoded from the state register so reset removes the strobe at once.
  assign sel_valid   = (r_state == S_CONFIRM);
  assign menu_sel    = r_menu_sel;
  assign o_dbg_state = r_state;

  // Displayed index only moves at the start of vertical blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblnk_d  <= 1'b0;
      r_disp_sel <= 2'd0;
    end else begin
      r_vblnk_d <= in.vblnk;
      if (in.vblnk && !r_vblnk_d) r_disp_sel <= r_menu_sel;
    end
  end

  // Box limits for the displayed item, all in 11-bit unsigned arithmetic.
  always_comb begin
    w_y0          = 11'(ITEM_Y0) + 11'(r_disp_sel) * 11'(ITEM_PITCH);
    w_y_hi        = w_y0 + 11'(ITEM_H - 1);
    w_yi_lo       = w_y0 + 11'(BORDER);
    w_yi_hi       = w_y0 + 11'(ITEM_H - 1 - BORDER);
    w_in_box      = (in.hcount >= X_LO) && (in.hcount <= X_HI) &&
                    (in.vcount >= w_y0) && (in.vcount <= w_y_hi);
    w_in_interior = (in.hcount >= XI_LO) && (in.hcount <= XI_HI) &&
                    (in.vcount >= w_yi_lo) && (in.vcount <= w_yi_hi);
    w_cursor_on   = w_in_box && !w_in_interior && !in.hblnk && !in.vblnk;
  end

  // One-cycle registered pass-through with the frame colour overlaid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= in.hcount;
      out.vcount <= in.vcount;
      out.hsync  <= in.hsync;
      out.vsync  <= in.vsync;
      out.hblnk  <= in.hblnk;
      out.vblnk  <= in.vblnk;
      out.rgb    <= w_cursor_on ? CUR_RGB : in.rgb;
    end
  end

endmodule

// File: tb/tb_menu_cursor.sv
// Bench for menu_cursor: key stimulus and pixel stimulus push expectations
// into queues, a negedge monitor pops them whenever the DUT shows a result.
module tb_menu_cursor;
  import menu_pkg::*;

  localparam int ITEMS = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       key_up = 1'b0, key_down = 1'b0, key_enter = 1'b0;
  logic [1:0] menu_sel;
  logic       sel_valid;
  nav_state_t dbg_state;

  vga_if vga_in ();
  vga_if vga_out ();

  menu_cursor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_up      (key_up),
    .key_down    (key_down),
    .key_enter   (key_enter),
    .in          (vga_in),
    .out         (vga_out),
    .menu_sel    (menu_sel),
    .sel_valid   (sel_valid),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [1:0]  sv_exp_q[$];
  int          sv_cyc_q[$];
  logic [1:0]  sel_exp_q[$];
  logic [37:0] pix_exp_q[$];
  int          pix_cyc_q[$];

  // Reference model of the selection and the displayed cursor row.
  int   model_sel  = 0;
  int   model_disp = 0;
  logic prev_vb    = 1'b0;

  function automatic logic in_frame(input int x, input int y, input int disp);
    int  y0;
    logic box, inner;
    y0    = 300 + disp * 80;
    box   = (x >= 412) && (x <= 611) && (y >= y0) && (y <= y0 + 47);
    inner = (x >= 415) && (x <= 608) && (y >= y0 + 3) && (y <= y0 + 44);
    return box && !inner;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [37:0] out_vec();
    return {vga_out.hcount, vga_out.vcount, vga_out.hsync, vga_out.vsync,
            vga_out.hblnk, vga_out.vblnk, vga_out.rgb};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic press(input logic u, input logic d, input logic e,
                       input int hold, input int gap);
    @(posedge clk); #1;
    key_up = u; key_down = d; key_enter = e;
    if (e) begin
      sv_exp_q.push_back(2'(model_sel));
      sv_cyc_q.push_back(cyc + 2);
    end else if (u && !d) begin
      model_sel = (model_sel + ITEMS - 1) % ITEMS;
      sel_exp_q.push_back(2'(model_sel));
    end else if (d && !u) begin
      model_sel = (model_sel + 1) % ITEMS;
      sel_exp_q.push_back(2'(model_sel));
    end
    repeat (hold) @(posedge clk);
    #1;
    key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    check("menu_sel_after_key", 64'(menu_sel), 64'(model_sel));
  endtask

  task automatic goto_sel(input int target);
    while (model_sel != target) press(1'b0, 1'b1, 1'b0, 1, 2);
  endtask

  task automatic drive_pix(input int x, input int y, input logic hb, input logic vb,
                           input logic [11:0] rgb);
    logic        hs, vs;
    logic [11:0] er;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    vga_in.hcount = 11'(x); vga_in.vcount = 11'(y);
    vga_in.hsync = hs; vga_in.vsync = vs;
    vga_in.hblnk = hb; vga_in.vblnk = vb; vga_in.rgb = rgb;
    er = (!hb && !vb && in_frame(x, y, model_disp)) ? 12'hFF0 : rgb;
    pix_exp_q.push_back({11'(x), 11'(y), hs, vs, hb, vb, er});
    pix_cyc_q.push_back(cyc + 1);
    if (vb && !prev_vb) model_disp = model_sel;
    prev_vb = vb;
  endtask

  task automatic vga_zero();
    vga_in.hcount = '0; vga_in.vcount = '0; vga_in.hsync = 1'b0; vga_in.vsync = 1'b0;
    vga_in.hblnk = 1'b0; vga_in.vblnk = 1'b0; vga_in.rgb = '0;
  endtask

  // ---------------- monitor ----------------
  logic [1:0]  last_sel = 2'd0;
  logic [1:0]  mon_sel;
  int          mon_cyc;
  logic [37:0] mon_pix;

  always @(negedge clk) begin
    if (rst_n) begin
      while (sv_cyc_q.size() > 0 && sv_cyc_q[0] < cyc) begin
        checks++; failures++;
        $display("FAIL sel_valid_missing: no pulse seen at cycle %0d, required menu_sel=%0d",
                 sv_cyc_q[0], sv_exp_q[0]);
        void'(sv_cyc_q.pop_front()); void'(sv_exp_q.pop_front());
      end
      if (sel_valid) begin
        checks++;
        if (sv_exp_q.size() == 0) begin
          failures++;
          $display("FAIL sel_valid_unexpected: pulse at cycle %0d menu_sel=%0d, required none",
                   cyc, menu_sel);
        end else begin
          mon_sel = sv_exp_q.pop_front();
          mon_cyc = sv_cyc_q.pop_front();
          if (mon_cyc != cyc || menu_sel !== mon_sel) begin
            failures++;
            $display("FAIL sel_valid_pulse: cycle %0d sel %0d, required cycle %0d sel %0d",
                     cyc, menu_sel, mon_cyc, mon_sel);
          end
        end
      end
      if (menu_sel !== last_sel) begin
        checks++;
        if (sel_exp_q.size() == 0) begin
          failures++;
          $display("FAIL menu_sel_change: changed to %0d, required no change", menu_sel);
        end else begin
          mon_sel = sel_exp_q.pop_front();
          if (menu_sel !== mon_sel) begin
            failures++;
            $display("FAIL menu_sel_change: got %0d required %0d", menu_sel, mon_sel);
          end
        end
        last_sel = menu_sel;
      end
    end else begin
      last_sel = 2'd0;
    end

    while (pix_cyc_q.size() > 0 && pix_cyc_q[0] < cyc) begin
      checks++; failures++;
      $display("FAIL pixel_missed: expected output at cycle %0d not compared", pix_cyc_q[0]);
      void'(pix_cyc_q.pop_front()); void'(pix_exp_q.pop_front());
    end
    if (pix_cyc_q.size() > 0 && pix_cyc_q[0] == cyc) begin
      void'(pix_cyc_q.pop_front());
      mon_pix = pix_exp_q.pop_front();
      checks++;
      if (out_vec() !== mon_pix) begin
        failures++;
        $display("FAIL pixel_out: got x=%0d y=%0d flags=%b rgb=%h, required x=%0d y=%0d flags=%b rgb=%h",
                 out_vec()[37:27], out_vec()[26:16], out_vec()[15:12], out_vec()[11:0],
                 mon_pix[37:27], mon_pix[26:16], mon_pix[15:12], mon_pix[11:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int r, hold, gap;
    vga_zero();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_menu_sel", 64'(menu_sel), 64'd0);
    check("rst_sel_valid", 64'(sel_valid), 64'd0);
    check("rst_out", 64'(out_vec()), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Three downs wrap 1,2,0 then one up wraps back to 2.
    press(1'b0, 1'b1, 1'b0, 1, 3);
    press(1'b0, 1'b1, 1'b0, 2, 3);
    press(1'b0, 1'b1, 1'b0, 1, 3);
    press(1'b1, 1'b0, 1'b0, 2, 3);

    // Up and down together leave the selection alone.
    press(1'b1, 1'b1, 1'b0, 2, 3);

    // Enter at selection 1, with down pulses while enter is held.
    goto_sel(1);
    @(posedge clk); #1;
    key_enter = 1'b1;
    sv_exp_q.push_back(2'd1);
    sv_cyc_q.push_back(cyc + 2);
    repeat (4) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      #1 key_down = 1'b1;
      @(posedge clk);
      #1 key_down = 1'b0;
      @(posedge clk);
    end
    #1 key_enter = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("enter_hold_sel", 64'(menu_sel), 64'd1);
    check("enter_hold_state", 64'(dbg_state), 64'(S_IDLE));

    // Random key activity.
    for (int i = 0; i < 40; i++) begin
      r    = $urandom_range(0, 9);
      hold = $urandom_range(1, 3);
      if (r >= 7) press(1'b0, 1'b0, 1'b1, hold, $urandom_range(4, 6));
      else if (r == 6) press(1'b1, 1'b1, 1'b0, hold, $urandom_range(2, 4));
      else if (r >= 3) press(1'b0, 1'b1, 1'b0, hold, $urandom_range(2, 4));
      else press(1'b1, 1'b0, 1'b0, hold, $urandom_range(2, 4));
    end

    // Cursor only moves at the vblnk rise.
    goto_sel(0);
    drive_pix(0, 770, 1'b1, 1'b1, 12'h123);
    drive_pix(0, 0, 1'b0, 1'b0, 12'h124);
    goto_sel(1);
    drive_pix(412, 300, 1'b0, 1'b0, 12'h0A5);
    drive_pix(413, 345, 1'b0, 1'b0, 12'h0A6);
    drive_pix(412, 380, 1'b0, 1'b0, 12'h0A7);
    drive_pix(500, 400, 1'b0, 1'b0, 12'h0A8);
    drive_pix(0, 770, 1'b1, 1'b1, 12'h0A9);
    drive_pix(0, 0, 1'b0, 1'b0, 12'h0AA);
    drive_pix(412, 380, 1'b0, 1'b0, 12'h5A5);
    drive_pix(500, 400, 1'b0, 1'b0, 12'h5A6);
    drive_pix(611, 427, 1'b0, 1'b0, 12'h5A7);
    drive_pix(412, 300, 1'b0, 1'b0, 12'h5A8);
    drive_pix(412, 380, 1'b1, 1'b0, 12'h5A9);
    drive_pix(412, 381, 1'b0, 1'b1, 12'h5AA);
    drive_pix(0, 0, 1'b0, 1'b0, 12'h5AB);

    // Random pixels around the item column.
    for (int i = 0; i < 200; i++) begin
      drive_pix($urandom_range(405, 620), $urandom_range(290, 480),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
                12'($urandom_range(0, 4095)));
    end
    drive_pix(0, 0, 1'b0, 1'b0, 12'h000);
    repeat (3) @(posedge clk);
    #1;

    // Reset while in CONFIRM, with down held through reset.
    goto_sel(2);
    @(posedge clk); #1;
    key_enter = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("confirm_before_rst", 64'(sel_valid), 64'd1);
    rst_n = 1'b0;
    key_enter = 1'b0;
    key_down  = 1'b1;
    vga_zero();
    model_sel  = 0;
    model_disp = 0;
    prev_vb    = 1'b0;
    #1;
    check("rst_mid_sel_valid", 64'(sel_valid), 64'd0);
    check("rst_mid_menu_sel", 64'(menu_sel), 64'd0);
    check("rst_mid_out", 64'(out_vec()), 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'(S_IDLE));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 key_down = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("held_key_no_edge", 64'(menu_sel), 64'd0);
    press(1'b0, 1'b1, 1'b0, 1, 3);

    repeat (5) @(posedge clk);
    #1;
    check("sel_valid_q_empty", 64'(sv_exp_q.size()), 64'd0);
    check("menu_sel_q_empty", 64'(sel_exp_q.size()), 64'd0);
    check("pixel_q_empty", 64'(pix_exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
